mult_serial: RTL

- Digit-serial N x N multiplier for the garbled-circuit arithmetic library.
- A start/done handshake replaces the free-running shift register of the earlier multi-cycle multiplier.
- Both operands are latched once, then B is consumed D bits per cycle, LSB digit first.
- Adds a signed (two's complement) mode and an optional accumulate mode (c <= c + a*b), so MAC chains need no external adder.

---
 rtl/mult_pkg.sv | 26 ++
 rtl/mult_digit.sv | 29 ++
 rtl/mult_serial.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the digit-serial multiplier.
//   state_t     : controller states IDLE -> RUN (CC cycles) -> FIX -> IDLE
//   cycles_of   : number of RUN cycles (N / D)
//   cnt_width   : digit counter width, wide enough to hold CC
//   params_ok   : elaboration-time legality check for N and D
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    function automatic int unsigned cycles_of(input int unsigned n, input int unsigned d);
        return (d == 0) ? 1 : n / d;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned cc);
        return $clog2(cc + 1);
    endfunction

    function automatic bit params_ok(input int unsigned n, input int unsigned d);
        return (n > 0) && (d > 0) && (d <= n) && ((n % d) == 0);
    endfunction

endpackage

// File: rtl/mult_digit.sv
// mult_digit: combinational N x D partial product.
//   i_a            : multiplicand (N bits)
//   i_digit        : one D-bit digit of the multiplier
//   i_a_signed     : treat i_a as two's complement
//   i_digit_signed : treat i_digit as two's complement (top digit in signed mode)
//   o_prod         : product, N+D+1 bits, two's complement
module mult_digit
    import mult_pkg::*;
#(
    parameter int unsigned N = 128,
    parameter int unsigned D = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [D-1:0] i_digit,
    input  logic         i_a_signed,
    input  logic         i_digit_signed,
    output logic [N+D:0] o_prod
);

    logic [N+D:0] w_a_ext;
    logic [N+D:0] w_d_ext;

    // Both operands sign/zero extended to the output width; the truncated
    // unsigned product is then the exact two's complement product.
    assign w_a_ext = {{(D + 1){i_a_signed & i_a[N-1]}}, i_a};
    assign w_d_ext = {{(N + 1){i_digit_signed & i_digit[D-1]}}, i_digit};
    assign o_prod  = w_a_ext * w_d_ext;

endmodule

// File: rtl/mult_serial.sv
// mult_serial: digit-serial N x N multiplier with start/done handshake,
// optional two's complement mode and optional accumulate (c <= c + a*b).
//   clk, rst    : clock, synchronous active-high reset
//   start       : request, sampled only when idle
//   signed_mode : operands/result two's complement (latched at start)
//   acc_en      : add product to current c (latched at start)
//   a, b        : N-bit operands (latched at start)
//   busy        : operation in progress (RUN and FIX)
//   done        : one-cycle pulse, c valid
//   c           : 2N-bit result register
module mult_serial
    import mult_pkg::*;
#(
    parameter int unsigned N = 128,
    parameter int unsigned D = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic           acc_en,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] c
);

    localparam int unsigned CC = cycles_of(N, D);
    localparam int unsigned CW = cnt_width(CC);
    localparam logic [CW-1:0] LAST = CW'(CC - 1);

    generate
        if (!params_ok(N, D)) begin : g_bad_params
            $error("mult_serial: N must be a positive multiple of D");
        end
    endgenerate

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_accept;
    logic           w_busy;

    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic           r_signed;
    logic           r_acc;
    logic [N:0]     r_hi;
    logic [N-1:0]   r_lo;
    logic [2*N-1:0] r_c;
    logic           r_done;

    logic           w_last;
    logic [N+D:0]   w_pp;
    logic [N+D:0]   w_hi;
    logic [N-1:0]   w_lo_next;

    assign w_last = (r_cnt == LAST);

    mult_digit #(
        .N(N),
        .D(D)
    ) u_digit (
        .i_a           (r_a),
        .i_digit       (r_b[D-1:0]),
        .i_a_signed    (r_signed),
        .i_digit_signed(r_signed & w_last),
        .o_prod        (w_pp)
    );

    // Partial sum P = {r_hi, r_lo} (2N+1 bits, signed). The digit product is
    // added into the top part, then P shifts right by D: the low D bits of the
    // sum drop into r_lo, the rest becomes the new (sign-extended) r_hi.
    assign w_hi = {{D{r_hi[N]}}, r_hi} + w_pp;

    generate
        if (D == N) begin : g_lo_full
            assign w_lo_next = w_hi[D-1:0];
        end else begin : g_lo_shift
            assign w_lo_next = {w_hi[D-1:0], r_lo[N-1:D]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_busy      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_acc    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_c      <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_signed <= signed_mode;
                        r_acc    <= acc_en;
                        r_hi     <= '0;
                        r_lo     <= '0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_hi  <= w_hi[N+D:D];
                    r_lo  <= w_lo_next;
                    r_b   <= r_b >> D;
                    r_cnt <= r_cnt + CW'(1);
                end
                FIX: begin
                    r_c    <= {r_hi[N-1:0], r_lo} + (r_acc ? r_c : '0);
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = w_busy;
    assign done = r_done;
    assign c    = r_c;

endmodule
